// File: rtl/fact_bus_master.sv
// Bus master that drives a memory-mapped factorial slave: it writes N, sets go, polls STATUS, then reads the 64-bit result.
// Latency is 7 cycles from start to done with an immediate grant and done on the first poll; it stalls in ARB until M_grant. Optional FACT_BUS_MASTER_TIMEOUT_EN.
module fact_bus_master #(
  parameter logic [15:0] BASE_ADDR = 16'h7000,
  parameter int          POLL_GAP  = 4,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  n_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        timeout,
  output logic        M_req,
  input  logic        M_grant,
  output logic        M_wr,
  output logic [15:0] M_address,
  output logic [31:0] M_dout,
  input  logic [31:0] M_din
);

  typedef enum logic [3:0] {
    IDLE, ARB, WR_N, WR_GO, RD_ST, GAP, RD_HI, RD_LO, FIN
  } state_t;

  localparam logic [3:0] GAP_LAST = (POLL_GAP == 0) ? 4'd0 : 4'(POLL_GAP - 1);

  state_t     state, next_state;
  logic [5:0] n_q;
  logic [3:0] gap_cnt;
  logic       poll_last;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    M_req      = 1'b0;
    M_wr       = 1'b0;
    M_address  = 16'h0000;
    M_dout     = 32'h0000_0000;
    case (state)
      IDLE: if (start) next_state = ARB;
      ARB: begin
        busy  = 1'b1;
        M_req = 1'b1;
        if (M_grant) next_state = WR_N;
      end
      WR_N: begin
        busy       = 1'b1;
        M_req      = 1'b1;
        M_wr       = 1'b1;
        M_address  = BASE_ADDR;
        M_dout     = {26'b0, n_q};
        next_state = WR_GO;
      end
      WR_GO: begin
        busy       = 1'b1;
        M_req      = 1'b1;
        M_wr       = 1'b1;
        M_address  = BASE_ADDR + 16'h0004;
        M_dout     = 32'h0000_0001;
        next_state = RD_ST;
      end
      RD_ST: begin
        busy      = 1'b1;
        M_req     = 1'b1;
        M_address = BASE_ADDR + 16'h0008;
        if (M_din[0])          next_state = RD_HI;
        else if (poll_last)    next_state = IDLE;
        else if (POLL_GAP == 0) next_state = RD_ST;
        else                   next_state = GAP;
      end
      GAP: begin
        busy  = 1'b1;
        M_req = 1'b1;
        if (gap_cnt == GAP_LAST) next_state = RD_ST;
      end
      RD_HI: begin
        busy       = 1'b1;
        M_req      = 1'b1;
        M_address  = BASE_ADDR + 16'h000C;
        next_state = RD_LO;
      end
      RD_LO: begin
        busy       = 1'b1;
        M_req      = 1'b1;
        M_address  = BASE_ADDR + 16'h0010;
        next_state = FIN;
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      n_q     <= 6'd0;
      result  <= 64'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= next_state;
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (state == IDLE && start) n_q <= n_in;
      if (state == RD_HI) result[63:32] <= M_din;
      if (state == RD_LO) result[31:0]  <= M_din;
    end
  end

`ifdef FACT_BUS_MASTER_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT + 1);
  logic [PW-1:0] poll_cnt;
  logic          timeout_q;

  // poll_last marks the final permitted STATUS read of this request
  assign poll_last = (poll_cnt == PW'(TIMEOUT - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == IDLE && start) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == RD_ST) begin
      poll_cnt <= poll_cnt + 1'b1;
      if (!M_din[0] && poll_last) timeout_q <= 1'b1;
    end
  end
`else
  assign poll_last = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
